// File: rtl/ps2_keymatrix_if.sv
// Keyboard event port: the CPU pops raw {ext, brk, code} events from the
// front end's queue and sees the sticky overflow flag.
interface ps2_keymatrix_if;
  logic       fifo_rd;
  logic       fifo_valid;
  logic [9:0] fifo_data;
  logic       overflow;

  modport master (output fifo_rd, input fifo_valid, fifo_data, overflow);
  modport slave  (input fifo_rd, output fifo_valid, fifo_data, overflow);
endinterface

// File: rtl/ps2_keymatrix.sv
// PS/2 keyboard front end: frame receiver, E0/F0/E1 decoder, keymap ROM lookup
// into an active-low ROWS x COLS key matrix, raw event FIFO and hotkey requests.
//
// state  | meaning
// IDLE   | waiting for a decoded event; map_addr shows it while it is taken
// LOOKUP | keymap ROM data for the event is latched
// APPLY  | valid entries write brk into the addressed matrix keys
module ps2_keymatrix #(
  parameter int ROWS    = 8,
  parameter int COLS    = 5,
  parameter int TIMEOUT = 2000,
  parameter int DEPTH   = 8,
  localparam int RB = (ROWS > 2) ? $clog2(ROWS) : 1,
  localparam int CB = (COLS > 2) ? $clog2(COLS) : 1,
  localparam int EW = 1 + RB + CB
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ce,
  input  logic [1:0]        ps2,
  input  logic [ROWS-1:0]   a,
  output logic [COLS-1:0]   dout,
  output logic [8:0]        map_addr,
  input  logic [2*EW-1:0]   map_data,
  ps2_keymatrix_if.slave    fifo,
  output logic [7:0]        err_count,
  output logic              reset_req,
  output logic              boot_req,
  output logic              nmi_req
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, LOOKUP, APPLY} state_t;

  logic [7:0]    sr;
  logic          armed, dat, stb;
  logic [3:0]    cnt;
  logic [7:0]    sh;
  logic          par, rx_vld;
  logic [TW-1:0] tmr;
  logic          ext, brk, slot_full, take, push, pop, wr, full, empty, ovf;
  logic [2:0]    skip;
  logic [9:0]    slot, ev_q;
  logic [8:0]    addr_q;
  logic [2*EW-1:0] ent;
  state_t        state, nxt;
  logic [ROWS-1:0][COLS-1:0] key;
  logic [1:0]    hit;
  logic [1:0][RB-1:0] er;
  logic [1:0][CB-1:0] ec;
  logic [9:0]    mem [DEPTH];
  logic [AW:0]   wp, rp;
  logic f5, f11, f12, ctrl_l, ctrl_r, alt_l, alt_r, del, bs;

  // A bit is strobed once the sampled PS/2 clock has been high 8 samples, then low 8.
  assign stb = ce & armed & (sr == 8'h00);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sr <= '0; armed <= 1'b0; dat <= 1'b1;
    end else if (ce) begin
      sr  <= {sr[6:0], ps2[0]};
      dat <= ps2[1];
      if (sr == 8'hFF)
        armed <= 1'b1;
      else if (stb)
        armed <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0; sh <= '0; par <= 1'b0; rx_vld <= 1'b0; tmr <= '0; err_count <= '0;
    end else if (ce) begin
      rx_vld <= 1'b0;
      if (stb) begin
        tmr <= TW'(TIMEOUT - 1);
        case (cnt)
          4'd0: if (!dat) cnt <= 4'd1;
          4'd9: begin par <= dat; cnt <= 4'd10; end
          4'd10: begin
            cnt <= 4'd0;
            if (dat && (^{sh, par}))
              rx_vld <= 1'b1;
            else if (err_count != 8'hFF)
              err_count <= err_count + 8'd1;
          end
          default: begin sh <= {dat, sh[7:1]}; cnt <= cnt + 4'd1; end
        endcase
      end else if (cnt != 4'd0) begin
        if (tmr == '0) begin
          cnt <= 4'd0;
          if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        end else begin
          tmr <= tmr - TW'(1);
        end
      end
    end
  end

  // sh still holds the accepted byte here; the next frame cannot shift in yet.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ext <= 1'b0; brk <= 1'b0; skip <= '0; slot <= '0; slot_full <= 1'b0;
    end else if (ce) begin
      if (take) slot_full <= 1'b0;
      if (rx_vld) begin
        if (skip != 3'd0)       skip <= skip - 3'd1;
        else if (sh == 8'hE1)   skip <= 3'd7;
        else if (sh == 8'hE0)   ext <= 1'b1;
        else if (sh == 8'hF0)   brk <= 1'b1;
        else begin
          slot <= {ext, brk, sh}; slot_full <= 1'b1; ext <= 1'b0; brk <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    nxt  = state;
    take = 1'b0;
    case (state)
      IDLE:    if (slot_full) begin take = 1'b1; nxt = LOOKUP; end
      LOOKUP:  nxt = APPLY;
      APPLY:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign push = ce & take;
  // The ROM sees the address in the same clock the event is taken, so its data is ready in LOOKUP.
  assign map_addr = (state == IDLE && slot_full) ? {slot[9], slot[7:0]} : addr_q;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      ec[i]  = ent[i*EW +: CB];
      er[i]  = ent[i*EW + CB +: RB];
      hit[i] = ent[i*EW + EW - 1] && (32'(er[i]) < ROWS) && (32'(ec[i]) < COLS);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE; addr_q <= '0; ev_q <= '0; ent <= '0; key <= '1;
    end else if (ce) begin
      state <= nxt;
      if (push) begin addr_q <= {slot[9], slot[7:0]}; ev_q <= slot; end
      if (state == LOOKUP) ent <= map_data;
      if (state == APPLY)
        for (int i = 0; i < 2; i++)
          if (hit[i]) key[er[i]][ec[i]] <= ev_q[8];
    end
  end

  always_comb begin
    dout = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        dout[c] = dout[c] & (a[r] | key[r][c]);
  end

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign pop   = ce & fifo.fifo_rd & ~empty;
  assign wr    = push & (~full | pop);
  assign fifo.fifo_valid = ~empty;
  assign fifo.fifo_data  = mem[rp[AW-1:0]];
  assign fifo.overflow   = ovf;

  always_ff @(posedge clock) begin
    if (wr) mem[wp[AW-1:0]] <= slot;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wp <= '0; rp <= '0; ovf <= 1'b0;
    end else begin
      if (wr)  wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      if (push && !wr) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      f5 <= 1'b0; f11 <= 1'b0; f12 <= 1'b0; ctrl_l <= 1'b0; ctrl_r <= 1'b0;
      alt_l <= 1'b0; alt_r <= 1'b0; del <= 1'b0; bs <= 1'b0;
      nmi_req <= 1'b0; reset_req <= 1'b0; boot_req <= 1'b0;
    end else if (ce) begin
      if (push) begin
        case ({slot[9], slot[7:0]})
          9'h003:  f5     <= ~slot[8];
          9'h078:  f11    <= ~slot[8];
          9'h007:  f12    <= ~slot[8];
          9'h014:  ctrl_l <= ~slot[8];
          9'h114:  ctrl_r <= ~slot[8];
          9'h011:  alt_l  <= ~slot[8];
          9'h111:  alt_r  <= ~slot[8];
          9'h171:  del    <= ~slot[8];
          9'h066:  bs     <= ~slot[8];
          default: ;
        endcase
      end
      nmi_req   <= f5;
      reset_req <= f12 & (ctrl_l | ctrl_r | alt_l | alt_r | del);
      boot_req  <= f11 & (ctrl_l | ctrl_r | alt_l | alt_r | bs);
    end
  end
endmodule

// File: tb/tb_ps2_keymatrix.sv
// Self-checking bench for ps2_keymatrix: serial PS/2 frames against a
// behavioural keyboard model (pressed-key sets, event queue, matrix array).
module tb_ps2_keymatrix;
  localparam int ROWS = 8, COLS = 5, TIMEOUT = 300, DEPTH = 8;
  localparam int RB = 3, CB = 3, EW = 7, HP = 10;

  logic clock = 1'b0, reset, ce;
  logic [1:0] ps2;
  logic [ROWS-1:0] a;
  logic [COLS-1:0] dout;
  logic [8:0] map_addr;
  logic [2*EW-1:0] map_data;
  logic [7:0] err_count;
  logic reset_req, boot_req, nmi_req;

  ps2_keymatrix_if kif();

  ps2_keymatrix #(.ROWS(ROWS), .COLS(COLS), .TIMEOUT(TIMEOUT), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .ce(ce), .ps2(ps2), .a(a), .dout(dout),
    .map_addr(map_addr), .map_data(map_data), .fifo(kif), .err_count(err_count),
    .reset_req(reset_req), .boot_req(boot_req), .nmi_req(nmi_req));

  always #5 clock = ~clock;

  logic [2*EW-1:0] rom [512];
  always @(posedge clock) map_data <= rom[map_addr];

  int checks = 0, errors = 0;
  bit mkey [ROWS][COLS];
  bit down [512];
  logic [9:0] mq [$];
  bit m_ovf, m_ext, m_brk;
  int m_err, m_skip;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) mkey[r][c] = 1'b1;
    for (int i = 0; i < 512; i++) down[i] = 1'b0;
    mq.delete();
    m_ovf = 0; m_ext = 0; m_brk = 0; m_err = 0; m_skip = 0;
  endtask

  task automatic model_event(input bit ext, input bit brk, input logic [7:0] b);
    logic [8:0] ad;
    logic [EW-1:0] e;
    int row, col;
    ad = {ext, b};
    if (mq.size() < DEPTH) mq.push_back({ext, brk, b}); else m_ovf = 1;
    down[ad] = !brk;
    for (int i = 0; i < 2; i++) begin
      e = rom[ad][i*EW +: EW];
      row = int'(e[RB+CB-1:CB]);
      col = int'(e[CB-1:0]);
      if (e[EW-1] && row < ROWS && col < COLS) mkey[row][col] = brk;
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (m_skip > 0) m_skip--;
    else if (b == 8'hE1) m_skip = 7;
    else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin model_event(m_ext, m_brk, b); m_ext = 0; m_brk = 0; end
  endtask

  function automatic logic [COLS-1:0] exp_do(input logic [ROWS-1:0] av);
    logic [COLS-1:0] v;
    v = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (!av[r] && !mkey[r][c]) v[c] = 1'b0;
    return v;
  endfunction

  task automatic send_bits(input logic [7:0] b, input bit badpar, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~(^b)) ^ badpar, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2[1] = f[i];
      repeat (HP) @(negedge clock);
      ps2[0] = 1'b0;
      repeat (HP) @(negedge clock);
      ps2[0] = 1'b1;
    end
    ps2[1] = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b, 1'b0, 11);
    model_byte(b);
    repeat (30) @(negedge clock);
  endtask

  task automatic check_state(input string tag);
    logic [ROWS-1:0] av;
    a = '0; #1; chk({tag, ".do_all"}, dout, exp_do(a));
    for (int k = 0; k < 2; k++) begin
      av = ROWS'($urandom); a = av; #1;
      chk({tag, ".do_rnd"}, dout, exp_do(av));
    end
    chk({tag, ".valid"}, kif.fifo_valid, mq.size() != 0);
    chk({tag, ".ovf"}, kif.overflow, m_ovf);
    chk({tag, ".err"}, err_count, (m_err > 255) ? 255 : m_err);
    chk({tag, ".nmi"}, nmi_req, down[9'h003]);
    chk({tag, ".rst"}, reset_req, down[9'h007] &
        (down[9'h014] | down[9'h114] | down[9'h011] | down[9'h111] | down[9'h171]));
    chk({tag, ".boot"}, boot_req, down[9'h078] &
        (down[9'h014] | down[9'h114] | down[9'h011] | down[9'h111] | down[9'h066]));
  endtask

  task automatic drain(input string tag);
    while (mq.size() != 0) begin
      chk({tag, ".head_v"}, kif.fifo_valid, 1'b1);
      chk({tag, ".head"}, kif.fifo_data, mq[0]);
      kif.fifo_rd = 1'b1;
      @(negedge clock);
      kif.fifo_rd = 1'b0;
      void'(mq.pop_front());
    end
    chk({tag, ".empty"}, kif.fifo_valid, 1'b0);
  endtask

  logic [7:0] code, pp_code;
  bit found, e, b;
  logic [7:0] specials [7] = '{8'h03, 8'h78, 8'h07, 8'h14, 8'h11, 8'h71, 8'h66};

  initial begin
    for (int i = 0; i < 512; i++) rom[i] = (2*EW)'($urandom);
    rom[9'h01C] = {7'b0000000, 7'b1001000};
    rom[9'h175] = {7'b1100011, 7'b1000000};
    ps2 = 2'b11; a = '1; ce = 1'b1; kif.fifo_rd = 1'b0; reset = 1'b1;
    model_reset();
    repeat (3) @(negedge clock);
    chk("rst.map_addr", map_addr, 9'h000);
    reset = 1'b0;
    repeat (12) @(negedge clock);
    check_state("rst");

    send_byte(8'h1C);
    a = 8'hFD; #1; chk("a_make", dout, 5'b11110);
    send_byte(8'hF0); send_byte(8'h1C);
    a = 8'hFD; #1; chk("a_break", dout, 5'b11111);
    chk("a_q0", mq[0], 10'h01C); chk("a_q1", mq[1], 10'h11C);
    drain("a");

    send_byte(8'hE0); send_byte(8'h75);
    a = 8'hEE; #1; chk("up_make", dout, 5'b10110);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    a = 8'hEE; #1; chk("up_break", dout, exp_do(8'hEE));
    check_state("up"); drain("up");

    send_bits(8'h1C, 1'b1, 11); m_err++; repeat (30) @(negedge clock);
    chk("par_err", err_count, 8'd1);
    check_state("par");
    send_bits(8'h1C, 1'b0, 4);
    repeat (TIMEOUT + 40) @(negedge clock); m_err++;
    send_byte(8'h1C);
    chk("tmo_err", err_count, 8'd2);
    a = 8'hFD; #1; chk("tmo_key", dout, 5'b11110);
    check_state("tmo"); drain("tmo");

    send_byte(8'h14); send_byte(8'h11); send_byte(8'h07);
    chk("hk_reset_on", reset_req, 1'b1);
    send_byte(8'hF0); send_byte(8'h07);
    chk("hk_reset_off", reset_req, 1'b0);
    send_byte(8'h14); send_byte(8'h03);
    chk("hk_nmi", nmi_req, 1'b1); chk("hk_boot", boot_req, 1'b0);
    check_state("hk"); drain("hk");

    send_byte(8'hE1);
    for (int i = 0; i < 7; i++) send_byte(8'($urandom_range(8'h01, 8'h7F)));
    check_state("pause");

    for (int i = 0; i < 9; i++) send_byte(8'($urandom_range(8'h20, 8'h5F)));
    chk("ovf_valid", kif.fifo_valid, 1'b1);
    chk("ovf_flag", kif.overflow, 1'b1);
    pp_code = 8'h15;
    found = 0;
    fork
      send_bits(pp_code, 1'b0, 11);
      begin
        for (int t = 0; t < 600 && !found; t++) begin
          @(negedge clock);
          if (map_addr == {1'b0, pp_code}) begin
            found = 1;
            kif.fifo_rd = 1'b1;
            @(negedge clock);
            kif.fifo_rd = 1'b0;
          end
        end
      end
    join
    chk("pp_sync", found, 1'b1);
    void'(mq.pop_front());
    model_byte(pp_code);
    repeat (30) @(negedge clock);
    chk("pp_ovf", kif.overflow, 1'b1);
    check_state("pp"); drain("pp");

    for (int n = 0; n < 24; n++) begin
      e = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 1) == 1);
      code = ($urandom_range(0, 2) == 0) ? specials[$urandom_range(0, 6)]
                                         : 8'($urandom_range(8'h01, 8'h83));
      if (e) send_byte(8'hE0);
      if (b) send_byte(8'hF0);
      send_byte(code);
      check_state("rnd");
      if ($urandom_range(0, 2) == 0) drain("rnd");
    end
    drain("rnd_end");

    send_byte(8'h1C);
    send_bits(8'h2A, 1'b0, 5);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    ps2 = 2'b11;
    model_reset();
    a = '0; #1;
    chk("mid_rst_do", dout, 5'b11111);
    chk("mid_rst_fifo", kif.fifo_valid, 1'b0);
    chk("mid_rst_err", err_count, 8'd0);
    repeat (12) @(negedge clock);
    send_byte(8'h1C);
    a = 8'hFD; #1; chk("post_rst_key", dout, 5'b11110);
    check_state("post"); drain("post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
